ps2_frame_rx: RTL and testbench

//  Receives 11-bit PS/2 device-to-host frames and presents each data byte with a one-cycle done tick.

---
 rtl/ps2_pkg.sv | 14 +
 rtl/ps2_clk_filter.sv | 47 ++++
 rtl/ps2_frame_rx.sv | 127 ++++++++++++
 tb/tb_ps2_frame_rx.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 device-to-host frame receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRx,
    StLoad
  } ps2_state_e;

  localparam int unsigned PS2_FRAME_BITS = 11;
  localparam logic        PS2_START      = 1'b0;
  localparam logic        PS2_STOP       = 1'b1;

endpackage

// File: rtl/ps2_clk_filter.sv
// Input conditioning for the PS/2 lines: synchronisers, ps2c glitch filter and fall detect.
module ps2_clk_filter #(
  parameter int unsigned FILTER_W = 8
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_ps2c,
  input  logic i_ps2d,
  output logic o_ps2d_sync,
  output logic o_fall
);

  logic [1:0]          ps2c_sync_q;
  logic [1:0]          ps2d_sync_q;
  logic [FILTER_W-1:0] filt_q, filt_d;
  logic                fclk_q, fclk_d;

  // Filtered clock only moves once every sample in the window agrees.
  always_comb begin
    filt_d = {ps2c_sync_q[1], filt_q[FILTER_W-1:1]};
    fclk_d = fclk_q;
    if (&filt_q) begin
      fclk_d = 1'b1;
    end else if (~|filt_q) begin
      fclk_d = 1'b0;
    end
  end

  // Synchroniser, filter window and filtered-clock registers; idle lines are high.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ps2c_sync_q <= '1;
      ps2d_sync_q <= '1;
      filt_q      <= '1;
      fclk_q      <= 1'b1;
    end else begin
      ps2c_sync_q <= {ps2c_sync_q[0], i_ps2c};
      ps2d_sync_q <= {ps2d_sync_q[0], i_ps2d};
      filt_q      <= filt_d;
      fclk_q      <= fclk_d;
    end
  end

  assign o_ps2d_sync = ps2d_sync_q[1];
  assign o_fall      = fclk_q & ~fclk_d;

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: FSM, frame shift register, bit counter and watchdog.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_W    = 8,
  parameter int unsigned TIMEOUT_CYC = 20000,
  parameter int unsigned TO_BIT      = 15
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_ps2d,
  input  logic       i_ps2c,
  input  logic       i_rx_en,
  output logic       o_rx_done_tick,
  output logic [7:0] o_data,
  output logic       o_parity_err,
  output logic       o_frame_err,
  output logic       o_timeout_tick,
  output logic       o_busy
);

  localparam logic [TO_BIT-1:0] ToLast = TO_BIT'(TIMEOUT_CYC - 1);

  logic ps2d_sync;
  logic fall;

  ps2_state_e                state_q, state_d;
  logic [PS2_FRAME_BITS-1:0] b_q, b_d;
  logic [3:0]                n_q, n_d;
  logic [TO_BIT-1:0]         wdog_q, wdog_d;
  logic [7:0]                data_q, data_d;
  logic                      perr_q, perr_d;
  logic                      ferr_q, ferr_d;
  logic                      done_q, done_d;
  logic                      to_q, to_d;

  ps2_clk_filter #(
    .FILTER_W(FILTER_W)
  ) u_filter (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_ps2c     (i_ps2c),
    .i_ps2d     (i_ps2d),
    .o_ps2d_sync(ps2d_sync),
    .o_fall     (fall)
  );

  // Next-state: frame capture, bit counting and watchdog; a fall always beats expiry.
  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    n_d     = n_q;
    wdog_d  = wdog_q;
    data_d  = data_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;
    to_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        wdog_d = '0;
        if (fall && i_rx_en) begin
          b_d     = {ps2d_sync, b_q[PS2_FRAME_BITS-1:1]};
          n_d     = 4'd9;
          state_d = StRx;
        end
      end
      StRx: begin
        if (fall) begin
          b_d    = {ps2d_sync, b_q[PS2_FRAME_BITS-1:1]};
          wdog_d = '0;
          if (n_q == 4'd0) begin
            state_d = StLoad;
          end else begin
            n_d = n_q - 4'd1;
          end
        end else if (wdog_q == ToLast) begin
          to_d    = 1'b1;
          state_d = StIdle;
        end else begin
          wdog_d = wdog_q + TO_BIT'(1);
        end
      end
      StLoad: begin
        data_d  = b_q[8:1];
        perr_d  = ~^b_q[9:1];
        ferr_d  = (b_q[0] != PS2_START) | (b_q[PS2_FRAME_BITS-1] != PS2_STOP);
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs; reset discards any partial frame.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= StIdle;
      b_q     <= '0;
      n_q     <= '0;
      wdog_q  <= '0;
      data_q  <= 8'h00;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      n_q     <= n_d;
      wdog_q  <= wdog_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      done_q  <= done_d;
      to_q    <= to_d;
    end
  end

  assign o_rx_done_tick = done_q;
  assign o_timeout_tick = to_q;
  assign o_data         = data_q;
  assign o_parity_err   = perr_q;
  assign o_frame_err    = ferr_q;
  assign o_busy         = (state_q != StIdle);

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Bench for ps2_frame_rx: directed and random PS/2 frames against a wire-level model.
module tb_ps2_frame_rx;

  localparam int unsigned FW  = 8;
  localparam int unsigned TO  = 200;
  localparam int unsigned TOB = 8;
  localparam int          LO  = 40;
  localparam int          HI  = 20;

  logic       i_clk     = 1'b0;
  logic       i_reset_n = 1'b0;
  logic       i_ps2d    = 1'b1;
  logic       i_ps2c    = 1'b1;
  logic       i_rx_en   = 1'b1;
  logic       o_rx_done_tick;
  logic [7:0] o_data;
  logic       o_parity_err;
  logic       o_frame_err;
  logic       o_timeout_tick;
  logic       o_busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int to_cnt = 0;
  int to_cyc = 0;
  int busy_seen = 0;
  int last_fall_cyc = 0;
  logic [7:0] cap_data = 8'h00;
  logic cap_perr = 1'b0;
  logic cap_ferr = 1'b0;

  ps2_frame_rx #(
    .FILTER_W   (FW),
    .TIMEOUT_CYC(TO),
    .TO_BIT     (TOB)
  ) dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_ps2d        (i_ps2d),
    .i_ps2c        (i_ps2c),
    .i_rx_en       (i_rx_en),
    .o_rx_done_tick(o_rx_done_tick),
    .o_data        (o_data),
    .o_parity_err  (o_parity_err),
    .o_frame_err   (o_frame_err),
    .o_timeout_tick(o_timeout_tick),
    .o_busy        (o_busy)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Tick monitor, sampled mid-cycle.
  always @(negedge i_clk) begin
    if (o_busy === 1'b1) busy_seen++;
    if (o_rx_done_tick === 1'b1 || o_timeout_tick === 1'b1)
      chk("tick_exclusive", 32'(o_rx_done_tick & o_timeout_tick), 32'd0);
    if (o_rx_done_tick === 1'b1) begin
      done_cnt++;
      cap_data = o_data;
      cap_perr = o_parity_err;
      cap_ferr = o_frame_err;
    end
    if (o_timeout_tick === 1'b1) begin
      to_cnt++;
      to_cyc = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // Wire frame: [0] start, [8:1] data LSB first, [9] odd parity, [10] stop.
  // e: 0 clean, 1 parity flipped, 2 start bit 1, 3 stop bit 0.
  function automatic logic [10:0] mk_frame(input logic [7:0] d, input int e);
    logic par;
    logic st;
    logic sp;
    par = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
    st  = 1'b0;
    sp  = 1'b1;
    if (e == 1) par = ~par;
    if (e == 2) st = 1'b1;
    if (e == 3) sp = 1'b0;
    return {sp, par, d, st};
  endfunction

  // Device drives nbits of f; bit stretch_idx arrives gap cycles after the previous fall.
  task automatic send(input logic [10:0] f, input int nbits, input bit glitch,
                      input int stretch_idx, input int gap);
    int pre;
    for (int i = 0; i < nbits; i++) begin
      pre = HI;
      if (i == stretch_idx) pre = gap - LO - HI;
      i_ps2d = f[i];
      if (glitch) begin
        tick(6);
        i_ps2c = 1'b0;
        tick(3);
        i_ps2c = 1'b1;
        tick(pre - 9);
      end else begin
        tick(pre);
      end
      i_ps2c = 1'b0;
      last_fall_cyc = cyc;
      tick(LO);
      i_ps2c = 1'b1;
      tick(HI);
    end
    i_ps2d = 1'b1;
  endtask

  task automatic expect_frame(input string tag, input int d0, input logic [7:0] d,
                              input logic perr, input logic ferr);
    tick(5);
    chk({tag, "_done"}, 32'(done_cnt), 32'(d0 + 1));
    chk({tag, "_data"}, 32'(cap_data), 32'(d));
    chk({tag, "_perr"}, 32'(cap_perr), 32'(perr));
    chk({tag, "_ferr"}, 32'(cap_ferr), 32'(ferr));
    chk({tag, "_hold"}, 32'(o_data), 32'(d));
  endtask

  initial begin
    int d0;
    int t0;
    logic [10:0] f;
    logic [7:0] rd;
    int re;

    tick(3);
    chk("rst_done", 32'(o_rx_done_tick), 32'd0);
    chk("rst_to", 32'(o_timeout_tick), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_flags", 32'({o_parity_err, o_frame_err}), 32'd0);
    i_reset_n = 1'b1;
    tick(5);

    // Clean 0x1C.
    d0 = done_cnt;
    busy_seen = 0;
    send(mk_frame(8'h1C, 0), 11, 1'b0, -1, 0);
    expect_frame("t1", d0, 8'h1C, 1'b0, 1'b0);
    chk("t1_busy_seen", 32'(busy_seen > 0), 32'd1);
    chk("t1_idle", 32'(o_busy), 32'd0);

    // 0xF0 with wrong parity.
    d0 = done_cnt;
    send(mk_frame(8'hF0, 1), 11, 1'b0, -1, 0);
    expect_frame("t2", d0, 8'hF0, 1'b1, 1'b0);

    // 0x5A with stop bit 0; rx_en dropped mid-frame must not abort it.
    d0 = done_cnt;
    f = mk_frame(8'h5A, 3);
    send(f, 3, 1'b0, -1, 0);
    i_rx_en = 1'b0;
    send(f >> 3, 8, 1'b0, -1, 0);
    expect_frame("t3", d0, 8'h5A, 1'b0, 1'b1);
    i_rx_en = 1'b1;

    // Stall after 5 bits: watchdog aborts, then a full frame decodes.
    d0 = done_cnt;
    t0 = to_cnt;
    send(mk_frame(8'h1C, 0), 5, 1'b0, -1, 0);
    tick(TO + 30);
    chk("t4_to_cnt", 32'(to_cnt), 32'(t0 + 1));
    chk("t4_to_lat", 32'(to_cyc - last_fall_cyc), 32'(2 + FW + 1 + TO));
    chk("t4_no_done", 32'(done_cnt), 32'(d0));
    chk("t4_idle", 32'(o_busy), 32'd0);
    d0 = done_cnt;
    send(mk_frame(8'h1C, 0), 11, 1'b0, -1, 0);
    expect_frame("t4b", d0, 8'h1C, 1'b0, 1'b0);

    // Short ps2c glitches are filtered out.
    d0 = done_cnt;
    send(mk_frame(8'h29, 0), 11, 1'b1, -1, 0);
    expect_frame("t5", d0, 8'h29, 1'b0, 1'b0);

    // Receiver disabled at frame start: frame ignored entirely.
    i_rx_en = 1'b0;
    d0 = done_cnt;
    t0 = to_cnt;
    busy_seen = 0;
    send(mk_frame(8'h29, 0), 11, 1'b0, -1, 0);
    tick(TO + 30);
    chk("t5b_busy", 32'(busy_seen), 32'd0);
    chk("t5b_done", 32'(done_cnt), 32'(d0));
    chk("t5b_to", 32'(to_cnt), 32'(t0));
    i_rx_en = 1'b1;

    // Fall landing exactly on watchdog expiry wins.
    d0 = done_cnt;
    t0 = to_cnt;
    send(mk_frame(8'h3A, 0), 11, 1'b0, 4, TO);
    expect_frame("edge", d0, 8'h3A, 1'b0, 1'b0);
    chk("edge_no_to", 32'(to_cnt), 32'(t0));

    // Reset mid-frame discards it silently.
    t0 = to_cnt;
    send(mk_frame(8'h77, 0), 6, 1'b0, -1, 0);
    tick(5);
    i_reset_n = 1'b0;
    tick(2);
    chk("t6_rst_busy", 32'(o_busy), 32'd0);
    chk("t6_rst_data", 32'(o_data), 32'd0);
    i_reset_n = 1'b1;
    tick(5);
    d0 = done_cnt;
    send(mk_frame(8'h12, 0), 11, 1'b0, -1, 0);
    expect_frame("t6", d0, 8'h12, 1'b0, 1'b0);
    tick(TO + 30);
    chk("t6_no_to", 32'(to_cnt), 32'(t0));
    chk("t6_one_done", 32'(done_cnt), 32'(d0 + 1));

    // Random frames with random error injection.
    for (int k = 0; k < 8; k++) begin
      rd = 8'($urandom_range(0, 255));
      re = int'($urandom_range(0, 3));
      d0 = done_cnt;
      send(mk_frame(rd, re), 11, 1'b0, -1, 0);
      expect_frame("rand", d0, rd, (re == 1), (re >= 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
